// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and master FSM state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    // Plain vector type so the encoding stays compatible with older tools.
    typedef logic [2:0] mst_state_t;

    localparam mst_state_t StIdle      = 3'd0;
    localparam mst_state_t StWaddrData = 3'd1;
    localparam mst_state_t StWresp     = 3'd2;
    localparam mst_state_t StRaddr     = 3'd3;
    localparam mst_state_t StRdata     = 3'd4;
    localparam mst_state_t StDone      = 3'd5;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns one local command into one AXI transaction and
// returns a single completion. Only one transaction is outstanding at a time.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic                      CMD_WRITE,
    input  logic [ADDRESS-1:0]        CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   CMD_WSTRB,

    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                RSP_RESP,

    output logic [ADDRESS-1:0]        M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,

    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,

    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,

    output logic [ADDRESS-1:0]        M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,

    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    mst_state_t              state_q, state_d;
    logic [ADDRESS-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    axi_resp_e               rsp_resp_q, rsp_resp_d;

    // Next-state, command capture and VALID sequencing.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_WDATA;
                    wstrb_d = CMD_WSTRB;
                    if (CMD_WRITE) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWaddrData;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StWaddrData: begin
                // AW and W retire independently; READY on an already-retired
                // channel only clears a flag that is already low.
                if (M_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (M_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                if (M_BVALID) begin
                    rsp_resp_d  = axi_resp_e'(M_BRESP);
                    rsp_rdata_d = '0;
                    state_d     = StDone;
                end
            end
            StRaddr: begin
                if (M_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (M_RVALID) begin
                    rsp_resp_d  = axi_resp_e'(M_RRESP);
                    rsp_rdata_d = M_RDATA;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (RSP_READY) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RespOkay;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // CMD_READY is gated by reset so it reads 0 while ARESETN is held low
    // and 1 in the very first cycle after release.
    assign CMD_READY = ARESETN && (state_q == StIdle);
    assign RSP_VALID = (state_q == StDone);
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_RESP  = rsp_resp_q;

    assign M_AWADDR  = addr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = (state_q == StWresp);
    assign M_ARADDR  = addr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = (state_q == StRdata);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: a directed table, hand-written
// reset and back-to-back sequences, and randomized transactions against a
// cycle-latency/response model of the AXI4-Lite master behaviour.
module tb_axi4_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic [3:0]  CMD_WSTRB;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_RESP;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [3:0]  M_WSTRB;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_RESP(RSP_RESP),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    // One transaction: command fields, slave wait states, slave response and
    // expected completion. d0/d1/d2 = AW/W/B waits for writes, AR/R for reads.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d0;
        int          d1;
        int          d2;
        int          hold;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic slave_idle();
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RRESP = 2'b00; M_RDATA = 32'h0;
        RSP_READY = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(CMD_READY), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(RSP_RDATA), 64'd0);
        chk({tag, "_rsp_resp"}, 64'(RSP_RESP), 64'd0);
        chk({tag, "_awaddr"}, 64'(M_AWADDR), 64'd0);
        chk({tag, "_wdata"}, 64'(M_WDATA), 64'd0);
        chk({tag, "_wstrb"}, 64'(M_WSTRB), 64'd0);
        chk({tag, "_araddr"}, 64'(M_ARADDR), 64'd0);
        chk({tag, "_valids"}, 64'({M_AWVALID, M_WVALID, M_ARVALID}), 64'd0);
        chk({tag, "_readies"}, 64'({M_BREADY, M_RREADY}), 64'd0);
    endtask

    // Called just after a negedge. Issues the command, plays the slave and the
    // response consumer, and checks channel behaviour every cycle.
    // rst_at > 0 pulls ARESETN low in that cycle after acceptance.
    task automatic run(input vec_t v, input bit hold_valid, input int rst_at, input string nm);
        int wait_c = 0;
        int k = 0;
        int lat = -1;
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0, h_c = 0;
        bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
        bit seen = 0, fin = 0;
        logic [31:0] got_rdata = '0;
        logic [1:0]  got_resp = '0;

        CMD_WRITE = v.write; CMD_ADDR = v.addr; CMD_WDATA = v.data; CMD_WSTRB = v.strb;
        CMD_VALID = 1'b1;
        while (CMD_READY !== 1'b1 && wait_c < 20) begin
            @(negedge ACLK);
            wait_c++;
        end
        chk({nm, "_accept_wait"}, 64'(wait_c), 64'd0);
        if (CMD_READY !== 1'b1) begin
            CMD_VALID = 1'b0;
            return;
        end

        while (!fin && k < 200) begin
            @(negedge ACLK);
            k++;
            if (!hold_valid) CMD_VALID = 1'b0;

            chk({nm, "_cmd_ready_busy"}, 64'(CMD_READY), 64'd0);
            chk({nm, "_rsp_valid"}, 64'(RSP_VALID), 64'(v.write ? b_done : r_done));
            if (v.write) begin
                chk({nm, "_awvalid"}, 64'(M_AWVALID), 64'(!aw_done));
                chk({nm, "_wvalid"}, 64'(M_WVALID), 64'(!w_done));
                chk({nm, "_bready"}, 64'(M_BREADY), 64'(aw_done && w_done && !b_done));
                chk({nm, "_rd_chan_idle"}, 64'({M_ARVALID, M_RREADY}), 64'd0);
                if (!aw_done) chk({nm, "_awaddr"}, 64'(M_AWADDR), 64'(v.addr));
                if (!w_done) begin
                    chk({nm, "_wdata"}, 64'(M_WDATA), 64'(v.data));
                    chk({nm, "_wstrb"}, 64'(M_WSTRB), 64'(v.strb));
                end
            end else begin
                chk({nm, "_arvalid"}, 64'(M_ARVALID), 64'(!ar_done));
                chk({nm, "_rready"}, 64'(M_RREADY), 64'(ar_done && !r_done));
                chk({nm, "_wr_chan_idle"}, 64'({M_AWVALID, M_WVALID, M_BREADY}), 64'd0);
                if (!ar_done) chk({nm, "_araddr"}, 64'(M_ARADDR), 64'(v.addr));
            end

            if (rst_at == k) begin
                ARESETN = 1'b0;
                slave_idle();
                @(negedge ACLK);
                check_reset_outputs({nm, "_rst"});
                ARESETN = 1'b1;
                CMD_VALID = 1'b0;
                #1;
                chk({nm, "_cmd_ready_after_rst"}, 64'(CMD_READY), 64'd1);
                return;
            end

            // Slave: readies after the programmed waits; unrelated channels get
            // random noise that must not disturb the master.
            if (v.write) begin
                M_BVALID = 1'b0;
                M_BRESP  = 2'($urandom_range(0, 3));
                if (aw_done && w_done && !b_done) begin
                    M_BVALID = (b_c >= v.d2);
                    M_BRESP  = v.resp;
                    b_c++;
                end
                if (!aw_done) begin
                    M_AWREADY = (aw_c >= v.d0);
                    aw_c++;
                end else begin
                    M_AWREADY = 1'($urandom_range(0, 1));
                end
                if (!w_done) begin
                    M_WREADY = (w_c >= v.d1);
                    w_c++;
                end else begin
                    M_WREADY = 1'($urandom_range(0, 1));
                end
                M_ARREADY = 1'($urandom_range(0, 1));
                M_RVALID  = 1'($urandom_range(0, 1));
                M_RDATA   = $urandom;
                M_RRESP   = 2'($urandom_range(0, 3));
                if (M_BVALID && M_BREADY) b_done = 1;
                if (M_AWREADY && !aw_done) aw_done = 1;
                if (M_WREADY && !w_done) w_done = 1;
            end else begin
                M_RVALID = 1'b0;
                M_RDATA  = $urandom;
                M_RRESP  = 2'($urandom_range(0, 3));
                if (ar_done && !r_done) begin
                    M_RVALID = (r_c >= v.d1);
                    M_RDATA  = v.rdata;
                    M_RRESP  = v.resp;
                    r_c++;
                end
                if (!ar_done) begin
                    M_ARREADY = (ar_c >= v.d0);
                    ar_c++;
                end else begin
                    M_ARREADY = 1'($urandom_range(0, 1));
                end
                M_AWREADY = 1'($urandom_range(0, 1));
                M_WREADY  = 1'($urandom_range(0, 1));
                M_BVALID  = 1'($urandom_range(0, 1));
                M_BRESP   = 2'($urandom_range(0, 3));
                if (M_RVALID && M_RREADY) r_done = 1;
                if (M_ARREADY && !ar_done) ar_done = 1;
            end

            // Response consumer: hold RSP_READY low for v.hold cycles.
            if (RSP_VALID) begin
                if (!seen) begin
                    seen = 1; lat = k; got_rdata = RSP_RDATA; got_resp = RSP_RESP;
                end else begin
                    chk({nm, "_rsp_rdata_stable"}, 64'(RSP_RDATA), 64'(got_rdata));
                    chk({nm, "_rsp_resp_stable"}, 64'(RSP_RESP), 64'(got_resp));
                end
                RSP_READY = (h_c >= v.hold);
                h_c++;
                if (RSP_READY) fin = 1;
            end else begin
                RSP_READY = 1'($urandom_range(0, 1));
            end
        end

        chk({nm, "_completed"}, 64'(fin), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({nm, "_rsp_resp"}, 64'(got_resp), 64'(v.exp_resp));
        chk({nm, "_rsp_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
        @(negedge ACLK);
        slave_idle();
        if (!hold_valid) CMD_VALID = 1'b0;
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        // Directed table: hand-computed response and cycle latency.
        //            wr  addr          data          strb d0 d1 d2 hld resp  rdata         eresp erdata        lat
        tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         3};
        tbl[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 0, 4, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         7};
        tbl[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 2, 0, 0, 2'b00, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 5};
        tbl[3] = '{1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'hC, 0, 0, 0, 5, 2'b10, 32'h0,         2'b10, 32'h0,         3};
        tbl[4] = '{1'b1, 32'h0000_0044, 32'h0F0F_F0F0, 4'h1, 3, 0, 1, 1, 2'b01, 32'h0,         2'b01, 32'h0,         7};
        tbl[5] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 2, 1, 0, 2, 2'b11, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D, 6};

        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0;
        slave_idle();
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESETN = 1'b1;
        #1;
        chk("reset_release_cmd_ready", 64'(CMD_READY), 64'd1);

        for (int i = 0; i < 6; i++) begin
            run(tbl[i], 1'b0, 0, $sformatf("vec%0d", i));
        end

        // Reset while waiting in RDATA, then a normal read.
        v = '{1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 6, 0, 0, 2'b00, 32'h1111_2222, 2'b00,
              32'h1111_2222, 9};
        run(v, 1'b0, 3, "rst_in_rdata");
        v = '{1'b0, 32'h0000_0084, 32'h0, 4'h0, 1, 1, 0, 0, 2'b00, 32'h3333_4444, 2'b00,
              32'h3333_4444, 5};
        run(v, 1'b0, 0, "read_after_rst");

        // Write then read with CMD_VALID held high throughout.
        v = '{1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 1, 0, 0, 2, 2'b00, 32'h0, 2'b00,
              32'h0, 4};
        run(v, 1'b1, 0, "b2b_write");
        v = '{1'b0, 32'h0000_0204, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h7777_8888, 2'b00,
              32'h7777_8888, 3};
        run(v, 1'b0, 0, "b2b_read");

        // Randomized transactions; expectations from the latency/response model.
        for (int i = 0; i < 40; i++) begin
            v.write = 1'($urandom_range(0, 1));
            v.addr  = $urandom & 32'hFFFF_FFFC;
            v.data  = $urandom;
            v.strb  = 4'($urandom_range(0, 15));
            v.d0    = $urandom_range(0, 3);
            v.d1    = $urandom_range(0, 3);
            v.d2    = $urandom_range(0, 2);
            v.hold  = $urandom_range(0, 2);
            v.resp  = 2'($urandom_range(0, 3));
            v.rdata = $urandom;
            v.exp_resp  = v.resp;
            v.exp_rdata = v.write ? 32'h0 : v.rdata;
            v.exp_lat   = v.write ? 3 + imax(v.d0, v.d1) + v.d2 : 3 + v.d0 + v.d1;
            run(v, 1'b0, 0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDRESS, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port ACLK  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port ARESETN  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port CMD_VALID  in  1  local command request.
REQ-006 SHALL have port CMD_READY  out  1  master accepts a command.
REQ-007 SHALL have port CMD_WRITE  in  1  1=write, 0=read.
REQ-008 SHALL have port CMD_ADDR  in  ADDRESS  target address.
REQ-009 SHALL have port CMD_WDATA  in  DATA_WIDTH  write data.
REQ-010 SHALL have port CMD_WSTRB  in  DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port RSP_VALID  out  1  completion available.
REQ-012 SHALL have port RSP_READY  in  1  local side consumes completion.
REQ-013 SHALL have port RSP_RDATA  out  DATA_WIDTH  read data (0 for writes).
REQ-014 SHALL have port RSP_RESP  out  2  BRESP or RRESP of the transaction.
REQ-015 SHALL have ports M_AWADDR out ADDRESS, M_AWVALID out 1, M_AWREADY in 1: write address channel.
REQ-016 SHALL have ports M_WDATA out DATA_WIDTH, M_WSTRB out DATA_WIDTH/8, M_WVALID out 1, M_WREADY in 1: write data channel.
REQ-017 SHALL have ports M_BRESP in 2, M_BVALID in 1, M_BREADY out 1: write response channel.
REQ-018 SHALL have ports M_ARADDR out ADDRESS, M_ARVALID out 1, M_ARREADY in 1: read address channel.
REQ-019 SHALL have ports M_RDATA in DATA_WIDTH, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1: read data channel.

Function
REQ-020 SHALL implement states IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE; one transaction outstanding at a time.
REQ-021 SHALL drive CMD_READY=1 only in IDLE; the command transfers on CMD_VALID&&CMD_READY, and its fields are registered.
REQ-022 IDLE->WADDR_DATA on an accepted write; IDLE->RADDR on an accepted read; M_AWVALID/M_WVALID or M_ARVALID SHALL go high the cycle after acceptance.
REQ-023 In WADDR_DATA, M_AWVALID and M_WVALID SHALL assert together and each SHALL drop independently the cycle after its own READY handshake; AW-before-W, W-before-AW and same-cycle acceptance are all legal.
REQ-024 WADDR_DATA->WRESP when both AW and W have handshaken; M_BREADY SHALL be 1 only in WRESP.
REQ-025 WRESP->DONE on M_BVALID&&M_BREADY; capture RSP_RESP=M_BRESP and RSP_RDATA=0.
REQ-026 RADDR->RDATA on M_ARVALID&&M_ARREADY; M_RREADY SHALL be 1 only in RDATA.
REQ-027 RDATA->DONE on M_RVALID&&M_RREADY; capture RSP_RDATA=M_RDATA and RSP_RESP=M_RRESP.
REQ-028 RSP_VALID SHALL be 1 only in DONE and held with stable data until RSP_READY; DONE->IDLE on RSP_VALID&&RSP_READY.
REQ-029 Once asserted, any AXI VALID SHALL hold, with stable address/data/strobe, until its handshake; VALID SHALL never wait on READY.
REQ-030 READY inputs high before VALID, or slave responses arriving outside WRESP/RDATA, SHALL have no effect.
REQ-031 Non-OKAY responses SHALL be passed through unchanged; no retry.
REQ-032 Minimum latency from command acceptance to RSP_VALID SHALL be 3 cycles for both reads and writes, with zero-wait slaves.

Reset
REQ-033 While ARESETN=0 at a clock edge: state=IDLE; all AXI VALID/READY outputs, CMD_READY and RSP_VALID=0; RSP_RDATA, RSP_RESP and the address/data/strobe outputs=0.
REQ-034 Reset mid-transaction SHALL abandon it immediately without completion; CMD_READY=1 on the first cycle after release.

Structure
REQ-035 A shared package axi4_lite_pkg SHALL hold the resp enum (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the master state typedef.
REQ-036 SHALL be a single module; no sub-module.

Verification
REQ-037 Write addr=0x0000_0010, data=0xDEAD_BEEF, strb=0xF to a zero-wait slave -> AW/W handshake in the same cycle, RSP_VALID 3 cycles after acceptance, RSP_RESP=00.
REQ-038 Write where the slave holds M_WREADY low 4 cycles after the AW handshake -> M_WVALID and M_WDATA stay stable, M_AWVALID low, and WRESP entered only after W.
REQ-039 Read addr=0x0000_0010 from a slave returning 0xDEAD_BEEF, RRESP=00, after 2 wait cycles -> RSP_RDATA=0xDEAD_BEEF, RSP_RESP=00.
REQ-040 Slave returns BRESP=10 -> RSP_RESP=10; RSP_READY low 5 cycles -> RSP_VALID and data held; CMD_READY=0 throughout.
REQ-041 ARESETN driven low while in RDATA -> next cycle all outputs at reset values; a subsequent read completes normally.
REQ-042 Back-to-back write then read with CMD_VALID held high -> second command accepted the cycle after the first response's RSP handshake.
